// File: rtl/snake_pkg.sv
// Shared constants, state encoding and tile helpers for the snake tile scanner.
package snake_pkg;

    localparam int unsigned GRID_COLS    = 10;
    localparam int unsigned GRID_ROWS    = 10;
    localparam int unsigned MAX_SEGMENTS = 100;
    localparam int unsigned COORD_W      = 32;
    localparam int unsigned POS_W        = 4;
    localparam int unsigned TILES        = GRID_COLS * GRID_ROWS;
    localparam int unsigned TILE_W       = $clog2(TILES);
    localparam int unsigned IDX_W        = $clog2(MAX_SEGMENTS);
    localparam int unsigned CNT_W        = $clog2(MAX_SEGMENTS + 1);
    localparam int unsigned BUS_W        = COORD_W * MAX_SEGMENTS;
    localparam int unsigned BASE_W       = $clog2(BUS_W);

    localparam logic [COORD_W-1:0] EMPTY_COORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SCAN   = 2'd2,
        COMMIT = 2'd3
    } scan_state_e;

    typedef struct packed {
        logic [POS_W-1:0] row;
        logic [POS_W-1:0] col;
    } tile_pos_t;

    // Row-major bit position of a tile; only meaningful for in-grid positions.
    function automatic logic [TILE_W-1:0] tile_index(input tile_pos_t pos);
        return TILE_W'(int'(pos.row) * GRID_COLS + int'(pos.col));
    endfunction

    function automatic logic tile_in_grid(input tile_pos_t pos);
        return (pos.row < POS_W'(GRID_ROWS)) && (pos.col < POS_W'(GRID_COLS));
    endfunction

endpackage

// File: rtl/snake_tile_scanner_if.sv
// Segment arrays, scan trigger, pixel-path query and scan status between game logic and scanner.
interface snake_tile_scanner_if;
    import snake_pkg::*;

    logic                 screenEnd;
    logic [BUS_W-1:0]     x_values;
    logic [BUS_W-1:0]     y_values;
    logic [POS_W-1:0]     query_col;
    logic [POS_W-1:0]     query_row;
    logic                 query_hit;
    logic                 busy;
    logic                 frame_ready;
    logic [CNT_W-1:0]     seg_count;
    logic                 collision;

    modport master (
        output screenEnd, x_values, y_values, query_col, query_row,
        input  query_hit, busy, frame_ready, seg_count, collision
    );

    modport slave (
        input  screenEnd, x_values, y_values, query_col, query_row,
        output query_hit, busy, frame_ready, seg_count, collision
    );

endinterface

// File: rtl/snake_tile_scanner_tile_bitmap.sv
// Shadow/committed tile-occupancy bitmaps with atomic commit and a registered tile query.
module tile_bitmap
    import snake_pkg::*;
(
    input  logic      clk25,
    input  logic      reset,
    input  logic      i_clear,
    input  logic      i_set,
    input  tile_pos_t i_set_pos,
    input  logic      i_commit,
    input  tile_pos_t i_query_pos,
    output logic      o_query_hit
);

    logic [TILES-1:0]  r_shadow;
    logic [TILES-1:0]  r_committed;
    logic              r_query_hit;
    logic [TILE_W-1:0] w_set_idx;
    logic [TILE_W-1:0] w_query_idx;
    logic              w_query_in_grid;

    assign w_set_idx       = tile_index(i_set_pos);
    assign w_query_idx     = tile_index(i_query_pos);
    assign w_query_in_grid = tile_in_grid(i_query_pos);

    // Query reads the committed copy, so a commit becomes visible one cycle later.
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_shadow    <= '0;
            r_committed <= '0;
            r_query_hit <= 1'b0;
        end else begin
            if (i_clear) begin
                r_shadow <= '0;
            end else if (i_set) begin
                r_shadow[w_set_idx] <= 1'b1;
            end
            if (i_commit) begin
                r_committed <= r_shadow;
            end
            r_query_hit <= w_query_in_grid && r_committed[w_query_idx];
        end
    end

    assign o_query_hit = r_query_hit;

endmodule

// File: rtl/snake_tile_scanner.sv
// Per-frame segment walker building a tile-occupancy bitmap for the VGA pixel path.
// Optional head/body collision detection is built when SNAKE_SCAN_COLLISION_EN is defined.
module snake_tile_scanner
    import snake_pkg::*;
(
    input  logic                 clk25,
    input  logic                 reset,
    snake_tile_scanner_if.slave  bus
);

    scan_state_e         r_state;
    scan_state_e         w_next;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_shadow_cnt;
    logic [CNT_W-1:0]    r_seg_count;
    logic                r_busy;
    logic                r_frame_ready;
    logic                r_collision;
    logic                w_shadow_coll;

    logic [BASE_W-1:0]   w_base;
    logic [COORD_W-1:0]  w_x;
    logic [COORD_W-1:0]  w_y;
    logic                w_valid;
    logic                w_in_grid;
    logic                w_last;
    tile_pos_t           w_pos;
    tile_pos_t           w_query_pos;
    logic                w_clear;
    logic                w_set;
    logic                w_commit;

    // Live view of the entry under the index; arrays are held stable by game logic.
    assign w_base      = BASE_W'(int'(r_idx) * COORD_W);
    assign w_x         = bus.x_values[w_base +: COORD_W];
    assign w_y         = bus.y_values[w_base +: COORD_W];
    assign w_valid     = (w_x != EMPTY_COORD) && (w_y != EMPTY_COORD);
    assign w_in_grid   = (w_x < GRID_COLS) && (w_y < GRID_ROWS);
    assign w_last      = (r_idx == IDX_W'(MAX_SEGMENTS - 1));
    assign w_pos       = '{row: w_y[POS_W-1:0], col: w_x[POS_W-1:0]};
    assign w_query_pos = '{row: bus.query_row, col: bus.query_col};

    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_set    = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.screenEnd) begin
                    w_next = CLEAR;
                end
            end
            CLEAR: begin
                w_clear = 1'b1;
                w_next  = SCAN;
            end
            SCAN: begin
                w_set = w_valid && w_in_grid;
                if (!w_valid || w_last) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                w_commit = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_shadow_cnt  <= '0;
            r_seg_count   <= '0;
            r_busy        <= 1'b0;
            r_frame_ready <= 1'b0;
            r_collision   <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_busy        <= (w_next != IDLE);
            r_frame_ready <= (w_next == COMMIT);
            case (r_state)
                CLEAR: begin
                    r_idx        <= '0;
                    r_shadow_cnt <= '0;
                end
                SCAN: begin
                    if (w_valid) begin
                        r_shadow_cnt <= r_shadow_cnt + 1'b1;
                        if (!w_last) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    r_seg_count <= r_shadow_cnt;
                    r_collision <= w_shadow_coll;
                end
                default: ;
            endcase
        end
    end

`ifdef SNAKE_SCAN_COLLISION_EN
    tile_pos_t r_head;
    logic      r_head_vld;
    logic      r_shadow_coll;

    // Head tile is captured at entry 0; later in-grid entries on that tile flag a collision.
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_head        <= '0;
            r_head_vld    <= 1'b0;
            r_shadow_coll <= 1'b0;
        end else if (r_state == CLEAR) begin
            r_head_vld    <= 1'b0;
            r_shadow_coll <= 1'b0;
        end else if (r_state == SCAN && w_valid && w_in_grid) begin
            if (r_idx == '0) begin
                r_head     <= w_pos;
                r_head_vld <= 1'b1;
            end else if (r_head_vld && (w_pos == r_head)) begin
                r_shadow_coll <= 1'b1;
            end
        end
    end

    assign w_shadow_coll = r_shadow_coll;
`else
    assign w_shadow_coll = 1'b0;
`endif

    tile_bitmap u_bitmap (
        .clk25       (clk25),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_set       (w_set),
        .i_set_pos   (w_pos),
        .i_commit    (w_commit),
        .i_query_pos (w_query_pos),
        .o_query_hit (bus.query_hit)
    );

    assign bus.busy        = r_busy;
    assign bus.frame_ready = r_frame_ready;
    assign bus.seg_count   = r_seg_count;
    assign bus.collision   = r_collision;

endmodule

// File: tb/tb_snake_tile_scanner.sv
// Self-checking bench for snake_tile_scanner: directed tables, corner sequences and random frames.
module tb_snake_tile_scanner;
    import snake_pkg::*;

`ifdef SNAKE_SCAN_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    typedef struct {
        int row;
        int col;
        int exp;
    } qvec_t;

    logic clk25 = 1'b0;
    logic reset;
    snake_tile_scanner_if bus();

    snake_tile_scanner dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );

    always #20 clk25 = ~clk25;

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0] mx [MAX_SEGMENTS];
    bit [31:0] my [MAX_SEGMENTS];
    int        m_cnt;
    int        m_lat;
    bit        m_coll;
    bit        m_bm [GRID_ROWS][GRID_COLS];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_arrays();
        for (int k = 0; k < MAX_SEGMENTS; k++) begin
            mx[k] = 32'hFFFF_FFFF;
            my[k] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic load_bus();
        for (int k = 0; k < MAX_SEGMENTS; k++) begin
            bus.x_values[k*32 +: 32] = mx[k];
            bus.y_values[k*32 +: 32] = my[k];
        end
    endtask

    // Reference: walk the list until an empty entry, count it, mark in-grid tiles, compare with head.
    task automatic model();
        bit        head_ok;
        bit [31:0] hx, hy;
        m_cnt   = 0;
        m_coll  = 1'b0;
        head_ok = 1'b0;
        hx      = 0;
        hy      = 0;
        for (int r = 0; r < GRID_ROWS; r++)
            for (int c = 0; c < GRID_COLS; c++)
                m_bm[r][c] = 1'b0;
        for (int k = 0; k < MAX_SEGMENTS; k++) begin
            if (mx[k] == 32'hFFFF_FFFF || my[k] == 32'hFFFF_FFFF) break;
            m_cnt++;
            if (mx[k] < GRID_COLS && my[k] < GRID_ROWS) begin
                m_bm[my[k]][mx[k]] = 1'b1;
                if (k == 0) begin
                    head_ok = 1'b1;
                    hx = mx[k];
                    hy = my[k];
                end else if (COLL_EN && head_ok && mx[k] == hx && my[k] == hy) begin
                    m_coll = 1'b1;
                end
            end
        end
        m_lat = (m_cnt < MAX_SEGMENTS) ? 3 + m_cnt : 2 + MAX_SEGMENTS;
    endtask

    task automatic query(input int row, input int col, output int hit);
        bus.query_row = 4'(row);
        bus.query_col = 4'(col);
        @(negedge clk25);
        hit = int'(bus.query_hit);
    endtask

    // Pulse screenEnd and return in the first frame_ready cycle; lat counts cycles after the pulse.
    task automatic run_scan(input int extra_at, output int lat);
        @(negedge clk25);
        bus.screenEnd = 1'b1;
        @(negedge clk25);
        bus.screenEnd = 1'b0;
        lat = -1;
        check("busy_in_clear", int'(bus.busy), 1);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (bus.frame_ready) begin
                lat = cyc;
                break;
            end
            bus.screenEnd = (cyc == extra_at);
            @(negedge clk25);
        end
        bus.screenEnd = 1'b0;
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk25);
            if (bus.frame_ready) pulses++;
        end
    endtask

    task automatic check_grid(input string name);
        int hit;
        for (int r = 0; r < GRID_ROWS; r++)
            for (int c = 0; c < GRID_COLS; c++) begin
                query(r, c, hit);
                check(name, hit, int'(m_bm[r][c]));
            end
    endtask

    task automatic check_frame(input string name, input int lat);
        check({name, "_latency"}, lat, m_lat);
        @(negedge clk25);
        check({name, "_pulse_len"}, int'(bus.frame_ready), 0);
        check({name, "_busy_after"}, int'(bus.busy), 0);
        check({name, "_seg_count"}, int'(bus.seg_count), m_cnt);
        check({name, "_collision"}, int'(bus.collision), int'(m_coll));
    endtask

    function automatic bit [31:0] rnd_coord();
        int r;
        r = $urandom_range(0, 15);
        if (r == 15) return 32'h0001_0000 + 32'($urandom_range(0, 100));
        return 32'(r);
    endfunction

    qvec_t tbl_a [8];
    qvec_t tbl_oor [4];

    initial begin
        int lat, hit, pulses, n;

        tbl_a[0] = '{3, 2, 1};
        tbl_a[1] = '{3, 3, 1};
        tbl_a[2] = '{3, 4, 1};
        tbl_a[3] = '{3, 5, 0};
        tbl_a[4] = '{3, 1, 0};
        tbl_a[5] = '{2, 3, 0};
        tbl_a[6] = '{0, 0, 0};
        tbl_a[7] = '{15, 15, 0};
        tbl_oor[0] = '{1, 1, 1};
        tbl_oor[1] = '{2, 2, 0};
        tbl_oor[2] = '{1, 12, 0};
        tbl_oor[3] = '{1, 2, 0};

        reset = 1'b1;
        bus.screenEnd = 1'b0;
        bus.query_row = '0;
        bus.query_col = '0;
        clear_arrays();
        load_bus();
        repeat (3) @(negedge clk25);
        reset = 1'b0;

        // Reset state
        query(0, 0, hit);
        check("rst_query_hit", hit, 0);
        check("rst_seg_count", int'(bus.seg_count), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_frame_ready", int'(bus.frame_ready), 0);
        check("rst_collision", int'(bus.collision), 0);

        // Three-segment row with terminator
        clear_arrays();
        mx[0] = 2; my[0] = 3;
        mx[1] = 3; my[1] = 3;
        mx[2] = 4; my[2] = 3;
        model();
        load_bus();
        run_scan(0, lat);
        check_frame("row3", lat);
        check("row3_latency_fixed", lat, 6);
        for (int i = 0; i < 8; i++) begin
            query(tbl_a[i].row, tbl_a[i].col, hit);
            check($sformatf("row3_q_r%0d_c%0d", tbl_a[i].row, tbl_a[i].col), hit, tbl_a[i].exp);
        end

        // Full array with an ignored second screenEnd, and old bitmap visible during COMMIT
        clear_arrays();
        for (int k = 0; k < MAX_SEGMENTS; k++) begin
            mx[k] = 32'(k % 10);
            my[k] = 32'(k / 10);
        end
        model();
        load_bus();
        run_scan(10, lat);
        check("full_latency_fixed", lat, 102);
        query(9, 9, hit);
        check("commit_cycle_old_bitmap", hit, 0);
        query(9, 9, hit);
        check("post_commit_new_bitmap", hit, 1);
        check("full_seg_count", int'(bus.seg_count), 100);
        check("full_collision", int'(bus.collision), int'(m_coll));
        count_pulses(40, pulses);
        check("full_single_pulse", pulses, 0);
        check_grid("full_grid");
        query(0, 10, hit);
        check("full_col_oob", hit, 0);
        query(10, 0, hit);
        check("full_row_oob", hit, 0);

        // Out-of-range entry is counted but sets nothing
        clear_arrays();
        mx[0] = 1;  my[0] = 1;
        mx[1] = 12; my[1] = 1;
        model();
        load_bus();
        run_scan(0, lat);
        check_frame("oor", lat);
        check("oor_seg_count_fixed", int'(bus.seg_count), 2);
        for (int i = 0; i < 4; i++) begin
            query(tbl_oor[i].row, tbl_oor[i].col, hit);
            check($sformatf("oor_q_r%0d_c%0d", tbl_oor[i].row, tbl_oor[i].col), hit, tbl_oor[i].exp);
        end

        // Head/body overlap
        clear_arrays();
        mx[0] = 5; my[0] = 5;
        mx[1] = 5; my[1] = 6;
        mx[2] = 5; my[2] = 5;
        model();
        load_bus();
        run_scan(0, lat);
        check_frame("coll", lat);
        check("coll_fixed", int'(bus.collision), int'(COLL_EN));

        // Random frames against the reference
        for (int f = 0; f < 12; f++) begin
            clear_arrays();
            n = ($urandom_range(0, 4) == 0) ? MAX_SEGMENTS : $urandom_range(0, MAX_SEGMENTS - 1);
            if (f == 0) n = 0;
            for (int k = 0; k < MAX_SEGMENTS; k++) begin
                mx[k] = rnd_coord();
                my[k] = rnd_coord();
            end
            if (n < MAX_SEGMENTS) begin
                if ($urandom_range(0, 1) == 1) mx[n] = 32'hFFFF_FFFF;
                else my[n] = 32'hFFFF_FFFF;
            end
            model();
            load_bus();
            run_scan(($urandom_range(0, 1) == 1) ? $urandom_range(2, 20) : 0, lat);
            check_frame($sformatf("rnd%0d", f), lat);
            check_grid($sformatf("rnd%0d_grid", f));
            query($urandom_range(10, 15), $urandom_range(0, 15), hit);
            check($sformatf("rnd%0d_row_oob", f), hit, 0);
        end

        // Reset during a scan: committed bitmap cleared, no frame_ready
        clear_arrays();
        for (int k = 0; k < MAX_SEGMENTS; k++) begin
            mx[k] = 32'(k % 10);
            my[k] = 32'(k / 10);
        end
        model();
        load_bus();
        run_scan(0, lat);
        check_frame("pre_rst", lat);
        @(negedge clk25);
        bus.screenEnd = 1'b1;
        @(negedge clk25);
        bus.screenEnd = 1'b0;
        repeat (4) @(negedge clk25);
        reset = 1'b1;
        @(negedge clk25);
        reset = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        count_pulses(130, pulses);
        check("midrst_no_frame_ready", pulses, 0);
        check("midrst_seg_count", int'(bus.seg_count), 0);
        check("midrst_collision", int'(bus.collision), 0);
        clear_arrays();
        model();
        check_grid("midrst_grid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
